// File: rtl/evn_seq_if.sv
// sys_bus_if: simple register bus with 1-cycle ack.
// Carries the block clock and synchronous active-low reset.
interface sys_bus_if #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input logic clk,
    input logic rstn
);
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wen;
    logic          ren;
    logic [DW-1:0] rdata;
    logic          err;
    logic          ack;

    modport m (
        input  clk, rstn, rdata, err, ack,
        output addr, wdata, wen, ren
    );

    modport s (
        input  clk, rstn, addr, wdata, wen, ren,
        output rdata, err, ack
    );
endinterface

// File: rtl/evn_seq.sv
// evn_seq: timed start / periodic trigger / stop event sequencer.
// Define EVN_SEQ_EXT_EVN_EN to add the external event input evi.
package evn_pkg;
    typedef struct packed {
        logic rst;
        logic str;
        logic stp;
        logic swt;
    } evn_t;
endpackage

module evn_seq
    import evn_pkg::*;
#(
    parameter int CW = 32,
    parameter int TN = 1
) (
    sys_bus_if.s          bus,
    output evn_t          evo,
    output logic [TN-1:0] trg
`ifdef EVN_SEQ_EXT_EVN_EN
    ,
    input  evn_t          evi
`endif
);

    localparam logic [4:0] A_CTL = 5'h00;
    localparam logic [4:0] A_DLY = 5'h04;
    localparam logic [4:0] A_PER = 5'h08;
    localparam logic [4:0] A_NUM = 5'h0C;
    localparam logic [4:0] A_CNT = 5'h10;
    localparam logic [4:0] A_MSK = 5'h14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [CW-1:0] cfg_dly;
    logic [CW-1:0] cfg_per;
    logic [CW-1:0] cfg_num;
    logic [TN-1:0] cfg_msk;
    logic [CW-1:0] sts_cnt;

    logic [CW-1:0] per_s;
    logic [CW-1:0] num_s;
    logic [TN-1:0] msk_s;

    logic [CW-1:0] tmr;
    logic [CW-1:0] tmr_nxt;
    logic [CW-1:0] pcnt;
    logic [CW-1:0] pcnt_nxt;
    logic [CW-1:0] cnt_nxt;
    evn_t          evo_nxt;
    logic [TN-1:0] trg_nxt;
    logic          arm_ok;

    logic [4:0]    addr;
    logic          ctl_wr;
    logic          cmd_arm;
    logic          cmd_abt;
    logic          cmd_rst;
    logic          trg_hit;
    logic          run_done;

    assign addr   = bus.addr[4:0];
    assign ctl_wr = bus.wen && (addr == A_CTL);

`ifdef EVN_SEQ_EXT_EVN_EN
    assign cmd_arm = (ctl_wr && bus.wdata[0]) || evi.str;
    assign cmd_abt = (ctl_wr && bus.wdata[1]) || evi.stp;
    assign cmd_rst = (ctl_wr && bus.wdata[2]) || evi.rst;
`else
    assign cmd_arm = ctl_wr && bus.wdata[0];
    assign cmd_abt = ctl_wr && bus.wdata[1];
    assign cmd_rst = ctl_wr && bus.wdata[2];
`endif

    // Stop is decided in the cycle that shows the last trigger.
    assign run_done = (num_s != '0) && evo.swt
                   && (sts_cnt == num_s);
    assign trg_hit  = (per_s != '0) && (pcnt == CW'(1));

    always_ff @(posedge bus.clk) begin
        if (!bus.rstn) begin
            bus.ack   <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ack <= bus.wen | bus.ren;
            bus.err <= 1'b0;
            if (bus.ren) begin
                case (addr)
                    A_CTL:   bus.rdata <= 32'(state);
                    A_DLY:   bus.rdata <= 32'(cfg_dly);
                    A_PER:   bus.rdata <= 32'(cfg_per);
                    A_NUM:   bus.rdata <= 32'(cfg_num);
                    A_CNT:   bus.rdata <= 32'(sts_cnt);
                    A_MSK:   bus.rdata <= 32'(cfg_msk);
                    default: bus.rdata <= 'x;
                endcase
            end
        end
    end

    always_ff @(posedge bus.clk) begin
        if (!bus.rstn) begin
            cfg_dly <= '0;
            cfg_per <= '0;
            cfg_num <= '0;
            cfg_msk <= '0;
        end else if (bus.wen) begin
            case (addr)
                A_DLY:   cfg_dly <= bus.wdata[CW-1:0];
                A_PER:   cfg_per <= bus.wdata[CW-1:0];
                A_NUM:   cfg_num <= bus.wdata[CW-1:0];
                A_MSK:   cfg_msk <= bus.wdata[TN-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge bus.clk) begin
        if (!bus.rstn) begin
            state   <= IDLE;
            tmr     <= '0;
            pcnt    <= '0;
            sts_cnt <= '0;
            evo     <= '0;
            trg     <= '0;
            per_s   <= '0;
            num_s   <= '0;
            msk_s   <= '0;
        end else begin
            state   <= state_nxt;
            tmr     <= tmr_nxt;
            pcnt    <= pcnt_nxt;
            sts_cnt <= cnt_nxt;
            evo     <= evo_nxt;
            trg     <= trg_nxt;
            if (arm_ok) begin
                per_s <= cfg_per;
                num_s <= cfg_num;
                msk_s <= cfg_msk;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        pcnt_nxt  = pcnt;
        cnt_nxt   = sts_cnt;
        evo_nxt   = '0;
        trg_nxt   = '0;
        arm_ok    = 1'b0;

        if (cmd_rst) begin
            evo_nxt.rst = 1'b1;
            state_nxt   = IDLE;
            cnt_nxt     = '0;
        end else if (cmd_abt) begin
            evo_nxt.stp = (state == RUN);
            state_nxt   = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_arm) begin
                        arm_ok   = 1'b1;
                        cnt_nxt  = '0;
                        tmr_nxt  = cfg_dly;
                        pcnt_nxt = cfg_per;
                        if (cfg_dly != '0) begin
                            state_nxt = DELAY;
                        end else begin
                            state_nxt   = RUN;
                            evo_nxt.str = 1'b1;
                        end
                    end
                end
                DELAY: begin
                    if (tmr == CW'(1)) begin
                        state_nxt   = RUN;
                        evo_nxt.str = 1'b1;
                        pcnt_nxt    = per_s;
                    end else begin
                        tmr_nxt = tmr - CW'(1);
                    end
                end
                RUN: begin
                    if (run_done) begin
                        state_nxt   = IDLE;
                        evo_nxt.stp = 1'b1;
                    end else if (trg_hit) begin
                        evo_nxt.swt = 1'b1;
                        trg_nxt     = msk_s;
                        cnt_nxt     = sts_cnt + CW'(1);
                        pcnt_nxt    = per_s;
                    end else if (per_s != '0) begin
                        pcnt_nxt = pcnt - CW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_evn_seq.sv
// tb_evn_seq: register vectors plus event scoreboard for evn_seq.
// Expected events are queued with their cycle and matched by a monitor.
module tb_evn_seq;
    import evn_pkg::*;

    localparam int TN = 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    evn_t evo;
    logic [TN-1:0] trg;
`ifdef EVN_SEQ_EXT_EVN_EN
    evn_t evi;
`endif

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int            cyc;
        evn_t          evo;
        logic [TN-1:0] trg;
    } ev_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } vec_t;

    ev_t expq[$];

    sys_bus_if bus (.clk(clk), .rstn(rstn));

    evn_seq #(.CW(32), .TN(TN)) dut (
        .bus (bus),
        .evo (evo),
        .trg (trg)
`ifdef EVN_SEQ_EXT_EVN_EN
        ,
        .evi (evi)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic wr(logic [4:0] a, logic [31:0] d);
        bus.addr  = 32'(a);
        bus.wdata = d;
        bus.wen   = 1'b1;
        @(negedge clk);
        bus.wen = 1'b0;
        chk("wr_ack", 32'(bus.ack), 32'd1);
    endtask

    task automatic rd(logic [4:0] a, output logic [31:0] d);
        bus.addr = 32'(a);
        bus.ren  = 1'b1;
        @(negedge clk);
        bus.ren = 1'b0;
        chk("rd_ack", 32'(bus.ack), 32'd1);
        chk("rd_err", 32'(bus.err), 32'd0);
        d = bus.rdata;
    endtask

    task automatic rdchk(string nm, logic [4:0] a, logic [31:0] e);
        logic [31:0] d;
        rd(a, d);
        chk(nm, d, e);
    endtask

    task automatic push(int c, logic r, logic s, logic p, logic w,
                        logic [TN-1:0] t);
        ev_t x;
        x.cyc     = c;
        x.evo     = '0;
        x.evo.rst = r;
        x.evo.str = s;
        x.evo.stp = p;
        x.evo.swt = w;
        x.trg     = t;
        expq.push_back(x);
    endtask

    task automatic wait_to(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic mon_step();
        ev_t x;
        if (!rstn) return;
        while (expq.size() != 0 && expq[0].cyc < cyc) begin
            x = expq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_evt: want evo=%b trg=%b at cyc %0d",
                     x.evo, x.trg, x.cyc);
        end
        if (evo != '0 || trg != '0) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexp_evt: got evo=%b trg=%b at cyc %0d",
                         evo, trg, cyc);
            end else begin
                x = expq.pop_front();
                if (x.cyc != cyc || x.evo != evo || x.trg != trg) begin
                    errors++;
                    $display("FAIL evt: got evo=%b trg=%b cyc %0d want evo=%b trg=%b cyc %0d",
                             evo, trg, cyc, x.evo, x.trg, x.cyc);
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        int   k;
        int   j;

        bus.addr  = '0;
        bus.wdata = '0;
        bus.wen   = 1'b0;
        bus.ren   = 1'b0;
`ifdef EVN_SEQ_EXT_EVN_EN
        evi = '0;
`endif
        vt[0] = '{5'h04, 32'd5,         32'd5};
        vt[1] = '{5'h08, 32'hdead_beef, 32'hdead_beef};
        vt[2] = '{5'h0C, 32'd7,         32'd7};
        vt[3] = '{5'h14, 32'd3,         32'd1};
        vt[4] = '{5'h10, 32'h55,        32'd0};
        vt[5] = '{5'h00, 32'd0,         32'd0};

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_evo", 32'(evo), 32'd0);
        chk("rst_trg", 32'(trg), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        rdchk("rst_state", 5'h00, 32'd0);
        rdchk("rst_per", 5'h08, 32'd0);

        for (int i = 0; i < 6; i++) begin
            wr(vt[i].addr, vt[i].wdata);
            rdchk($sformatf("vec%0d", i), vt[i].addr, vt[i].rexp);
        end

        // dly=3 per=4 num=2
        wr(5'h04, 32'd3);
        wr(5'h08, 32'd4);
        wr(5'h0C, 32'd2);
        wr(5'h14, 32'd1);
        k = cyc;
        push(k + 4,  0, 1, 0, 0, 1'b0);
        push(k + 8,  0, 0, 0, 1, 1'b1);
        push(k + 12, 0, 0, 0, 1, 1'b1);
        push(k + 13, 0, 0, 1, 0, 1'b0);
        wr(5'h00, 32'd1);
        rdchk("t1_delay", 5'h00, 32'd1);
        wait_to(k + 14);
        rdchk("t1_idle", 5'h00, 32'd0);
        rdchk("t1_cnt", 5'h10, 32'd2);

        // dly=0 per=1 unlimited, abort
        wr(5'h04, 32'd0);
        wr(5'h08, 32'd1);
        wr(5'h0C, 32'd0);
        k = cyc;
        push(k + 1, 0, 1, 0, 0, 1'b0);
        for (int i = 2; i <= 10; i++) push(k + i, 0, 0, 0, 1, 1'b1);
        push(k + 11, 0, 0, 1, 0, 1'b0);
        wr(5'h00, 32'd1);
        rdchk("t2_run", 5'h00, 32'd2);
        wait_to(k + 10);
        wr(5'h00, 32'd2);
        rdchk("t2_cnt", 5'h10, 32'd9);
        rdchk("t2_idle", 5'h00, 32'd0);

        // RST|ABORT|ARM in RUN
        wr(5'h08, 32'd5);
        k = cyc;
        push(k + 1, 0, 1, 0, 0, 1'b0);
        push(k + 6, 0, 0, 0, 1, 1'b1);
        wr(5'h00, 32'd1);
        wait_to(k + 7);
        rdchk("t3_cnt_pre", 5'h10, 32'd1);
        j = cyc;
        push(j + 1, 1, 0, 0, 0, 1'b0);
        wr(5'h00, 32'd7);
        rdchk("t3_state", 5'h00, 32'd0);
        rdchk("t3_cnt", 5'h10, 32'd0);
        rdchk("t3_cfg_kept", 5'h08, 32'd5);

        // abort in DELAY, shadowed per
        wr(5'h0C, 32'd3);
        wr(5'h08, 32'd7);
        wr(5'h04, 32'd100);
        k = cyc;
        wr(5'h00, 32'd1);
        wr(5'h08, 32'd2);
        rdchk("t4_delay", 5'h00, 32'd1);
        wait_to(k + 50);
        wr(5'h00, 32'd2);
        rdchk("t4_idle", 5'h00, 32'd0);
        wr(5'h04, 32'd0);
        k = cyc;
        push(k + 1, 0, 1, 0, 0, 1'b0);
        push(k + 3, 0, 0, 0, 1, 1'b1);
        push(k + 5, 0, 0, 0, 1, 1'b1);
        push(k + 7, 0, 0, 0, 1, 1'b1);
        push(k + 8, 0, 0, 1, 0, 1'b0);
        wr(5'h00, 32'd1);
        wait_to(k + 10);
        rdchk("t4_cnt", 5'h10, 32'd3);

        // second ARM during RUN ignored
        wr(5'h0C, 32'd0);
        wr(5'h08, 32'd3);
        k = cyc;
        push(k + 1,  0, 1, 0, 0, 1'b0);
        push(k + 4,  0, 0, 0, 1, 1'b1);
        push(k + 7,  0, 0, 0, 1, 1'b1);
        push(k + 10, 0, 0, 0, 1, 1'b1);
        push(k + 12, 0, 0, 1, 0, 1'b0);
        wr(5'h00, 32'd1);
        wait_to(k + 5);
        wr(5'h00, 32'd1);
        wait_to(k + 11);
        wr(5'h00, 32'd2);
        rdchk("t5_cnt", 5'h10, 32'd3);

        // rstn low mid-run
        wr(5'h08, 32'd2);
        k = cyc;
        push(k + 1, 0, 1, 0, 0, 1'b0);
        push(k + 3, 0, 0, 0, 1, 1'b1);
        push(k + 5, 0, 0, 0, 1, 1'b1);
        wr(5'h00, 32'd1);
        wait_to(k + 6);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_evo", 32'(evo), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        rdchk("t6_state", 5'h00, 32'd0);
        rdchk("t6_per", 5'h08, 32'd0);
        rdchk("t6_cnt", 5'h10, 32'd0);

`ifdef EVN_SEQ_EXT_EVN_EN
        k = cyc;
        push(k + 1, 0, 1, 0, 0, 1'b0);
        evi.str = 1'b1;
        @(negedge clk);
        evi = '0;
        rdchk("ext_run", 5'h00, 32'd2);
        j = cyc;
        push(j + 1, 0, 0, 1, 0, 1'b0);
        evi.stp = 1'b1;
        @(negedge clk);
        evi = '0;
        rdchk("ext_idle", 5'h00, 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
